// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit controller: op and state
// encodings, the arithmetic result payload and small op-class helpers.
// Imported by the interface, the arithmetic block and the controller.
package mdu_ctrl_pkg;

  localparam int unsigned MDU_W = 32;

  // E-stage MDU op encodings as produced by the CU.
  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_e;

  // Result of one mult/div; div0 marks a divide by zero (HI/LO left alone).
  typedef struct packed {
    logic [MDU_W-1:0] hi;
    logic [MDU_W-1:0] lo;
    logic             div0;
  } mdu_res_t;

  // Ops that start a multi-cycle operation.
  function automatic logic is_arith_op(md_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_mul_op(md_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage <-> MDU controller signal bundle.
//   E_md_op    : E-stage MDU op (md_op_e encoding)
//   E_rs_data  : forwarded rs (dividend / multiplicand / mthi, mtlo source)
//   E_rt_data  : forwarded rt (divisor / multiplier)
//   D_MDU      : D-stage instruction is an MDU op
//   E_md_rdata : mfhi/mflo read data (combinational)
//   busy       : mult/div in progress
//   stall_md   : freeze F/D, bubble E (combinational)
//   hi, lo     : architectural HI/LO
// master = pipeline side, slave = MDU controller.
interface mdu_ctrl_if;
  import mdu_ctrl_pkg::*;

  logic [3:0]       E_md_op;
  logic [MDU_W-1:0] E_rs_data;
  logic [MDU_W-1:0] E_rt_data;
  logic             D_MDU;
  logic [MDU_W-1:0] E_md_rdata;
  logic             busy;
  logic             stall_md;
  logic [MDU_W-1:0] hi;
  logic [MDU_W-1:0] lo;

  modport master (
    output E_md_op, E_rs_data, E_rt_data, D_MDU,
    input  E_md_rdata, busy, stall_md, hi, lo
  );

  modport slave (
    input  E_md_op, E_rs_data, E_rt_data, D_MDU,
    output E_md_rdata, busy, stall_md, hi, lo
  );

endinterface

// File: rtl/mdu_ctrl_arith.sv
// Combinational mult/div datapath.
//   i_op  : MDU op (only mult/multu/div/divu produce a result)
//   i_a   : rs operand
//   i_b   : rt operand
//   o_res : {hi, lo, div0}; div0 set for div/divu with a zero divisor
module mdu_ctrl_arith
  import mdu_ctrl_pkg::*;
(
  input  md_op_e           i_op,
  input  logic [MDU_W-1:0] i_a,
  input  logic [MDU_W-1:0] i_b,
  output mdu_res_t         o_res
);

  localparam int unsigned PW = 2 * MDU_W;

  logic [PW-1:0]    w_prod_s;
  logic [PW-1:0]    w_prod_u;
  logic             w_b_zero;
  logic [MDU_W-1:0] w_ub_safe;
  logic [MDU_W-1:0] w_uq;
  logic [MDU_W-1:0] w_ur;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [MDU_W-1:0] w_ma;
  logic [MDU_W-1:0] w_mb_safe;
  logic [MDU_W-1:0] w_mq;
  logic [MDU_W-1:0] w_mr;
  logic [MDU_W-1:0] w_sq;
  logic [MDU_W-1:0] w_sr;

  // Sign-extend to 64 bits; the low 64 bits of the product are exact.
  assign w_prod_s = {{MDU_W{i_a[MDU_W-1]}}, i_a} * {{MDU_W{i_b[MDU_W-1]}}, i_b};
  assign w_prod_u = {MDU_W'(0), i_a} * {MDU_W'(0), i_b};

  // Divisor forced to 1 on zero so the dividers never see 0 (no X).
  assign w_b_zero  = (i_b == '0);
  assign w_ub_safe = w_b_zero ? MDU_W'(1) : i_b;
  assign w_uq      = i_a / w_ub_safe;
  assign w_ur      = i_a % w_ub_safe;

  // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign w_a_neg   = i_a[MDU_W-1];
  assign w_b_neg   = i_b[MDU_W-1];
  assign w_ma      = w_a_neg ? (MDU_W'(0) - i_a) : i_a;
  assign w_mb_safe = w_b_zero ? MDU_W'(1) : (w_b_neg ? (MDU_W'(0) - i_b) : i_b);
  assign w_mq      = w_ma / w_mb_safe;
  assign w_mr      = w_ma % w_mb_safe;
  assign w_sq      = (w_a_neg ^ w_b_neg) ? (MDU_W'(0) - w_mq) : w_mq;
  assign w_sr      = w_a_neg ? (MDU_W'(0) - w_mr) : w_mr;

  // Result select.
  always_comb begin
    o_res = '0;
    unique case (i_op)
      MDU_MULT:  {o_res.hi, o_res.lo} = w_prod_s;
      MDU_MULTU: {o_res.hi, o_res.lo} = w_prod_u;
      MDU_DIV: begin
        o_res.hi   = w_sr;
        o_res.lo   = w_sq;
        o_res.div0 = w_b_zero;
      end
      MDU_DIVU: begin
        o_res.hi   = w_ur;
        o_res.lo   = w_uq;
        o_res.div0 = w_b_zero;
      end
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller in the E stage. Owns HI/LO,
// sequences mult/div with a fixed busy latency, raises stall_md while the
// D-stage instruction needs the MDU and the MDU is (or is about to be) busy,
// and serves mfhi/mflo for E-stage forwarding.
//   clk   : clock
//   reset : synchronous, active-high
//   bus   : mdu_ctrl_if slave (E-stage op/operands in; rdata/busy/stall/HI/LO out)
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  mdu_ctrl_if.slave   bus
);

  localparam int unsigned MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  mdu_state_e       r_state;
  mdu_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  mdu_res_t         r_pend;
  logic [MDU_W-1:0] r_hi;
  logic [MDU_W-1:0] r_lo;

  md_op_e           w_op;
  mdu_res_t         w_res;
  logic             w_start;
  logic             w_busy;
  logic             w_commit;
  logic             w_wr_hi;
  logic             w_wr_lo;
  logic             w_stall;
  logic [MDU_W-1:0] w_rdata;

  assign w_op = md_op_e'(bus.E_md_op);

  mdu_ctrl_arith u_arith (
    .i_op  (w_op),
    .i_a   (bus.E_rs_data),
    .i_b   (bus.E_rt_data),
    .o_res (w_res)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = is_mul_op(w_op) ? ST_MUL : ST_DIV;
      end
      ST_MUL, ST_DIV: begin
        if (r_cnt == CNT_W'(1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    w_start  = 1'b0;
    w_busy   = 1'b0;
    w_commit = 1'b0;
    w_wr_hi  = 1'b0;
    w_wr_lo  = 1'b0;
    w_rdata  = '0;
    w_busy   = (r_state != ST_IDLE);
    w_start  = (r_state == ST_IDLE) && is_arith_op(w_op);
    w_commit = w_busy && (r_cnt == CNT_W'(1));
    // Ops arriving while busy are protocol violations and are dropped.
    w_wr_hi  = !w_busy && (w_op == MDU_MTHI);
    w_wr_lo  = !w_busy && (w_op == MDU_MTLO);
    // Reads always see committed HI/LO, never the pending result.
    if (w_op == MDU_MFHI)      w_rdata = r_hi;
    else if (w_op == MDU_MFLO) w_rdata = r_lo;
    // Start term covers an MDU op in D right behind a starting mult/div.
    w_stall  = !reset && bus.D_MDU && (w_start || w_busy);
  end

  // Latency counter and pending result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_pend <= '0;
    end else if (w_start) begin
      r_cnt  <= is_mul_op(w_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      r_pend <= w_res;
    end else if (w_busy) begin
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

  // Architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit) begin
      if (!r_pend.div0) begin
        r_hi <= r_pend.hi;
        r_lo <= r_pend.lo;
      end
    end else begin
      if (w_wr_hi) r_hi <= bus.E_rs_data;
      if (w_wr_lo) r_lo <= bus.E_rs_data;
    end
  end

  assign bus.E_md_rdata = w_rdata;
  assign bus.busy       = w_busy;
  assign bus.stall_md   = w_stall;
  assign bus.hi         = r_hi;
  assign bus.lo         = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: reset, mult/multu/div/divu results and
// latency, stall_md around busy, divide by zero, mthi/mtlo/mfhi/mflo
// ordering, and reset abort of an in-flight divide.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  mdu_ctrl_if u_if ();

  mdu_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one E-stage op for the current cycle and let it settle.
  task automatic step(input md_op_e op, input logic [31:0] rs, input logic [31:0] rt,
                      input logic dmdu);
    u_if.E_md_op   = op;
    u_if.E_rs_data = rs;
    u_if.E_rt_data = rt;
    u_if.D_MDU     = dmdu;
    #1;
    if (!reset && op >= MDU_MULT && op <= MDU_MTLO)
      chk("proto_op_while_busy", 32'(u_if.busy), 32'd0);
  endtask

  // Start a mult/div, then hold bubbles through its busy window checking
  // that busy is high and HI/LO are untouched until the window closes.
  task automatic run_op(input string tag, input md_op_e op, input logic [31:0] rs,
                        input logic [31:0] rt, input int lat, input logic dmdu,
                        input logic [31:0] old_hi, input logic [31:0] old_lo,
                        input logic [31:0] new_hi, input logic [31:0] new_lo);
    step(op, rs, rt, dmdu);
    chk({tag, "_stall_start"}, 32'(u_if.stall_md), 32'(dmdu));
    tick();
    for (int i = 0; i < lat; i++) begin
      step(MDU_NONE, 32'd0, 32'd0, dmdu);
      chk({tag, "_busy"}, 32'(u_if.busy), 32'd1);
      chk({tag, "_stall_busy"}, 32'(u_if.stall_md), 32'(dmdu));
      chk({tag, "_hi_hold"}, u_if.hi, old_hi);
      chk({tag, "_lo_hold"}, u_if.lo, old_lo);
      tick();
    end
    step(MDU_NONE, 32'd0, 32'd0, dmdu);
    chk({tag, "_busy_done"}, 32'(u_if.busy), 32'd0);
    chk({tag, "_stall_done"}, 32'(u_if.stall_md), 32'd0);
    chk({tag, "_hi"}, u_if.hi, new_hi);
    chk({tag, "_lo"}, u_if.lo, new_lo);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Reset: stall must stay low even with a starting mult and an MDU op in D.
    reset = 1'b1;
    step(MDU_MULT, 32'd3, 32'd4, 1'b1);
    chk("rst_stall_pre", 32'(u_if.stall_md), 32'd0);
    tick();
    chk("rst_stall", 32'(u_if.stall_md), 32'd0);
    chk("rst_busy", 32'(u_if.busy), 32'd0);
    chk("rst_hi", u_if.hi, 32'd0);
    chk("rst_lo", u_if.lo, 32'd0);
    tick();
    reset = 1'b0;
    step(MDU_NONE, 32'd0, 32'd0, 1'b0);
    chk("idle_rdata", u_if.E_md_rdata, 32'd0);
    chk("idle_busy", 32'(u_if.busy), 32'd0);
    tick();

    // mult -3 * 5 = -15.
    run_op("mult", MDU_MULT, 32'hFFFF_FFFD, 32'd5, 5, 1'b0,
           32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    tick();
    step(MDU_MFLO, 32'd0, 32'd0, 1'b0);
    chk("mflo_read", u_if.E_md_rdata, 32'hFFFF_FFF1);
    tick();
    step(MDU_MFHI, 32'd0, 32'd0, 1'b0);
    chk("mfhi_read", u_if.E_md_rdata, 32'hFFFF_FFFF);
    tick();

    // multu 0xFFFFFFFF^2 = 0xFFFFFFFE_00000001.
    run_op("multu", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1'b0,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'hFFFF_FFFE, 32'h0000_0001);
    tick();

    // mult 0x80000000^2 (signed) = 2^62.
    run_op("mult_min", MDU_MULT, 32'h8000_0000, 32'h8000_0000, 5, 1'b0,
           32'hFFFF_FFFE, 32'h0000_0001, 32'h4000_0000, 32'h0000_0000);
    tick();

    // divu 17 / 5 = 3 rem 2.
    run_op("divu", MDU_DIVU, 32'd17, 32'd5, 10, 1'b0,
           32'h4000_0000, 32'h0000_0000, 32'd2, 32'd3);
    tick();

    // div -7 / 2 = -3 rem -1.
    run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b0,
           32'd2, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    tick();

    // div 0x80000000 / -1 -> LO=0x80000000, HI=0.
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0, 32'h8000_0000);
    tick();

    // mult in E with mflo in D: stall through start and all busy cycles.
    run_op("mult_stall", MDU_MULT, 32'd7, 32'd6, 5, 1'b1,
           32'd0, 32'h8000_0000, 32'd0, 32'h0000_002A);
    tick();
    step(MDU_MFLO, 32'd0, 32'd0, 1'b1);
    chk("mflo_after_stall", u_if.E_md_rdata, 32'h0000_002A);
    chk("stall_after_busy", 32'(u_if.stall_md), 32'd0);
    tick();

    // Divide by zero keeps HI/LO.
    step(MDU_MTHI, 32'h11, 32'd0, 1'b0);
    tick();
    step(MDU_MTLO, 32'h22, 32'd0, 1'b0);
    tick();
    run_op("div0", MDU_DIV, 32'd1234, 32'd0, 10, 1'b0,
           32'h11, 32'h22, 32'h11, 32'h22);
    tick();
    run_op("divu0", MDU_DIVU, 32'hFFFF_0000, 32'd0, 10, 1'b0,
           32'h11, 32'h22, 32'h11, 32'h22);
    tick();

    // mthi then mfhi; same-cycle read of HI sees the old value.
    step(MDU_MTHI, 32'hABCD, 32'd0, 1'b0);
    chk("mthi_hi_old", u_if.hi, 32'h11);
    chk("mthi_rdata", u_if.E_md_rdata, 32'd0);
    chk("mthi_stall", 32'(u_if.stall_md), 32'd0);
    tick();
    step(MDU_MFHI, 32'd0, 32'd0, 1'b1);
    chk("mfhi_new", u_if.E_md_rdata, 32'hABCD);
    chk("mfhi_stall", 32'(u_if.stall_md), 32'd0);
    tick();
    step(MDU_MTLO, 32'h5A5A, 32'd0, 1'b0);
    chk("mtlo_lo_old", u_if.lo, 32'h22);
    tick();
    step(MDU_MFLO, 32'd0, 32'd0, 1'b0);
    chk("mflo_new", u_if.E_md_rdata, 32'h5A5A);
    tick();

    // Reset in cycle 3 of a div aborts it; no later HI/LO write.
    step(MDU_DIV, 32'd100, 32'd3, 1'b0);
    tick();
    step(MDU_NONE, 32'd0, 32'd0, 1'b0);
    chk("abort_busy1", 32'(u_if.busy), 32'd1);
    tick();
    chk("abort_busy2", 32'(u_if.busy), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    chk("abort_busy3", 32'(u_if.busy), 32'd1);
    chk("abort_hi_pre", u_if.hi, 32'hABCD);
    tick();
    reset = 1'b0;
    #1;
    chk("abort_busy_clr", 32'(u_if.busy), 32'd0);
    chk("abort_hi_clr", u_if.hi, 32'd0);
    chk("abort_lo_clr", u_if.lo, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_hi_stay", u_if.hi, 32'd0);
      chk("abort_lo_stay", u_if.lo, 32'd0);
      chk("abort_busy_stay", 32'(u_if.busy), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
